// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that funnels C buffered write requests onto one
// register-file write port with a registered one-hot write enable.

module reg_write_arbiter_chan #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_valid,
  input  logic [N-1:0]  req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          issue,
  output logic          req_ready,
  output logic          held,
  output logic [N-1:0]  addr,
  output logic [DW-1:0] data
);
  logic          held_q, held_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  // Issuing entry may be replaced on the same edge for back-to-back writes.
  always_comb begin
    req_ready = ~Reset & (~held_q | issue);
    load      = req_valid & req_ready;
    held_d    = held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (load) begin
      held_d = 1'b1;
      addr_d = req_addr;
      data_d = req_data;
    end else if (issue) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign held = held_q;
  assign addr = addr_q;
  assign data = data_q;
endmodule

module reg_write_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int C       = 2,
  parameter int ZERO_RO = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [C-1:0]    ReqValid,
  input  logic [C*N-1:0]  ReqAddr,
  input  logic [C*DW-1:0] ReqData,
  output logic [C-1:0]    ReqReady,
  input  logic            Hold,
  output logic [2**N-1:0] WrEn,
  output logic [N-1:0]    WrAddr,
  output logic [DW-1:0]   WrData,
  output logic [C-1:0]    Grant
);
  localparam int M  = 2**N;
  localparam int PW = (C > 1) ? $clog2(C) : 1;

  logic [C-1:0]          held, sel;
  logic [C-1:0][N-1:0]   chan_addr;
  logic [C-1:0][DW-1:0]  chan_data;

  logic [PW-1:0] ptr_q, ptr_d, win;
  logic          found;
  int            idx;
  logic [N-1:0]  win_addr;
  logic [DW-1:0] win_data;

  logic [M-1:0]  wren_q, wren_d;
  logic [N-1:0]  wraddr_q, wraddr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic [C-1:0]  grant_q, grant_d;

  for (genvar i = 0; i < C; i++) begin : g_chan
    reg_write_arbiter_chan #(.N(N), .DW(DW)) u_chan (
      .Clk       (Clk),
      .Reset     (Reset),
      .req_valid (ReqValid[i]),
      .req_addr  (ReqAddr[i*N +: N]),
      .req_data  (ReqData[i*DW +: DW]),
      .issue     (sel[i]),
      .req_ready (ReqReady[i]),
      .held      (held[i]),
      .addr      (chan_addr[i]),
      .data      (chan_data[i])
    );
  end

  // First held channel at or after the pointer, wrapping; Hold blocks all issue.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < C; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= C) idx = idx - C;
      if (!found && !Hold && held[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    if (found) sel[win] = 1'b1;
    win_addr = chan_addr[win];
    win_data = chan_data[win];
  end

  always_comb begin
    wren_d   = '0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    grant_d  = '0;
    ptr_d    = ptr_q;
    if (found) begin
      wraddr_d = win_addr;
      wrdata_d = win_data;
      grant_d  = sel;
      ptr_d    = (int'(win) + 1 >= C) ? '0 : PW'(int'(win) + 1);
      // Read-only register 0: the write retires but nothing is enabled.
      if (!(ZERO_RO != 0 && win_addr == '0)) begin
        for (int j = 0; j < M; j++) wren_d[j] = (win_addr == N'(j));
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q    <= '0;
      wren_q   <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      grant_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      grant_q  <= grant_d;
    end
  end

  assign WrEn   = wren_q;
  assign WrAddr = wraddr_q;
  assign WrData = wrdata_q;
  assign Grant  = grant_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; a second instance runs with ZERO_RO=1
// on the same stimulus.

module tb_reg_write_arbiter;
  logic        Clk = 1'b0;
  logic        Reset, Hold;
  logic [1:0]  ReqValid;
  logic [7:0]  ReqAddr;
  logic [31:0] ReqData;

  logic [1:0]  rdy, rdy_z, gnt, gnt_z;
  logic [15:0] wren, wren_z, wdata, wdata_z;
  logic [3:0]  waddr, waddr_z;

  int tests = 0;
  int failed = 0;

  reg_write_arbiter #(.N(4), .DW(16), .C(2), .ZERO_RO(0)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .ReqReady(rdy), .Hold(Hold), .WrEn(wren),
    .WrAddr(waddr), .WrData(wdata), .Grant(gnt)
  );

  reg_write_arbiter #(.N(4), .DW(16), .C(2), .ZERO_RO(1)) dut_z (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .ReqReady(rdy_z), .Hold(Hold), .WrEn(wren_z),
    .WrAddr(waddr_z), .WrData(wdata_z), .Grant(gnt_z)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic [15:0] e_en, input logic [1:0] e_gnt);
    chk({tag, ".wren"}, 32'(wren), 32'(e_en));
    chk({tag, ".grant"}, 32'(gnt), 32'(e_gnt));
  endtask

  initial begin
    Reset = 1'b1; Hold = 1'b0; ReqValid = '0; ReqAddr = '0; ReqData = '0;
    tick(); tick();
    out("reset", 16'h0000, 2'b00);
    chk("reset.waddr", 32'(waddr), 32'h0);
    chk("reset.wdata", 32'(wdata), 32'h0);
    chk("reset.ready", 32'(rdy), 32'h0);

    Reset = 1'b0;
    #1 chk("idle.ready", 32'(rdy), 32'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      out("idle", 16'h0000, 2'b00);
      chk("idle.ready_loop", 32'(rdy), 32'h3);
      chk("idle.wdata", 32'(wdata), 32'h0);
    end

    // single write ch0 addr 5
    ReqValid = 2'b01; ReqAddr = {4'h0, 4'h5}; ReqData = {16'h0, 16'hBEEF};
    tick();
    ReqValid = 2'b00;
    out("single.accept", 16'h0000, 2'b00);
    tick();
    out("single.issue", 16'h0020, 2'b01);
    chk("single.waddr", 32'(waddr), 32'h5);
    chk("single.wdata", 32'(wdata), 32'hBEEF);
    chk("single.wren_z", 32'(wren_z), 32'h0020);
    tick();
    out("single.after", 16'h0000, 2'b00);
    chk("single.waddr_keep", 32'(waddr), 32'h5);
    chk("single.wdata_keep", 32'(wdata), 32'hBEEF);

    // contention; pointer now at ch1
    ReqValid = 2'b11; ReqAddr = {4'h9, 4'h3}; ReqData = {16'h0009, 16'h0003};
    tick();
    out("cont.accept", 16'h0000, 2'b00);
    chk("cont.ready0", 32'(rdy), 32'h2);
    tick();
    out("cont.1", 16'h0200, 2'b10);
    chk("cont.ready1", 32'(rdy), 32'h1);
    tick();
    out("cont.2", 16'h0008, 2'b01);
    chk("cont.waddr2", 32'(waddr), 32'h3);
    chk("cont.ready2", 32'(rdy), 32'h2);
    tick();
    out("cont.3", 16'h0200, 2'b10);
    chk("cont.wdata3", 32'(wdata), 32'h0009);
    ReqValid = 2'b00;
    tick();
    out("cont.drain0", 16'h0008, 2'b01);
    tick();
    out("cont.drain1", 16'h0200, 2'b10);
    tick();
    out("cont.empty", 16'h0000, 2'b00);
    chk("cont.ready_empty", 32'(rdy), 32'h3);

    // hold stall with ch1 buffered
    ReqValid = 2'b10; ReqAddr = {4'h2, 4'h0}; ReqData = {16'h2222, 16'h0};
    tick();
    ReqValid = 2'b00; Hold = 1'b1;
    #1 chk("hold.ready_pre", 32'(rdy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      out("hold.stall", 16'h0000, 2'b00);
      chk("hold.ready", 32'(rdy), 32'h1);
    end
    Hold = 1'b0;
    #1 chk("hold.ready_release", 32'(rdy), 32'h3);
    tick();
    out("hold.release", 16'h0004, 2'b10);
    chk("hold.wdata", 32'(wdata), 32'h2222);
    tick();
    out("hold.after", 16'h0000, 2'b00);

    // write to register 0 on both instances
    ReqValid = 2'b01; ReqAddr = {4'h0, 4'h0}; ReqData = {16'h0, 16'h1234};
    tick();
    ReqValid = 2'b00;
    tick();
    out("zero.rw", 16'h0001, 2'b01);
    chk("zero.ro_wren", 32'(wren_z), 32'h0);
    chk("zero.ro_grant", 32'(gnt_z), 32'h1);
    chk("zero.ro_waddr", 32'(waddr_z), 32'h0);
    chk("zero.ro_wdata", 32'(wdata_z), 32'h1234);
    chk("zero.ro_ready", 32'(rdy_z), 32'h3);
    tick();
    chk("zero.ro_after", 32'(gnt_z), 32'h0);

    // reset with both channels buffered (pointer at ch1)
    ReqValid = 2'b11; ReqAddr = {4'h9, 4'h3}; ReqData = {16'hAAAA, 16'h5555};
    tick();
    ReqValid = 2'b00; Reset = 1'b1;
    tick();
    out("rst.mid", 16'h0000, 2'b00);
    chk("rst.wdata", 32'(wdata), 32'h0);
    chk("rst.ready_in_reset", 32'(rdy), 32'h0);
    Reset = 1'b0;
    #1 chk("rst.ready_empty", 32'(rdy), 32'h3);
    for (int i = 0; i < 2; i++) begin
      tick();
      out("rst.dropped", 16'h0000, 2'b00);
    end
    ReqValid = 2'b11; ReqData = {16'h0B0B, 16'h0A0A};
    tick();
    ReqValid = 2'b00;
    tick();
    out("rst.first", 16'h0008, 2'b01);
    chk("rst.first_data", 32'(wdata), 32'h0A0A);
    tick();
    out("rst.second", 16'h0200, 2'b10);
    tick();
    out("rst.idle", 16'h0000, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
